// File: rtl/perf_event_monitor_if.sv
// Dump stream port of perf_event_monitor: valid/ready words carrying one counter each.
interface perf_event_monitor_if #(
  parameter int NUM_EVT = 5,
  parameter int CNT_W   = 32
);
  localparam int IDX_W = $clog2(NUM_EVT + 1);

  logic             dump_valid;
  logic             dump_ready;
  logic [IDX_W-1:0] dump_idx;
  logic [CNT_W-1:0] dump_data;
  logic             dump_last;

  modport master (output dump_valid, dump_idx, dump_data, dump_last, input dump_ready);
  modport slave  (input dump_valid, dump_idx, dump_data, dump_last, output dump_ready);
endinterface

// File: rtl/perf_event_monitor.sv
// Cycle + event counter bank that freezes on halt and streams its counts out.
// Define PERF_WRAP_EN for wrapping counters; default build saturates at max.
module perfCounter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (clr) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (inc) begin
`ifdef PERF_WRAP_EN
      cnt <= cnt + 1'b1;
      if (&cnt) ovf <= 1'b1;
`else
      if (&cnt) ovf <= 1'b1;
      else      cnt <= cnt + 1'b1;
`endif
    end
  end
endmodule

module perf_event_monitor #(
  parameter  int NUM_EVT = 5,
  parameter  int CNT_W   = 32,
  localparam int IDX_W   = $clog2(NUM_EVT + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [NUM_EVT-1:0] evt,
  input  logic               halt,
  input  logic               clr,
  input  logic [IDX_W-1:0]   rd_sel,
  output logic [CNT_W-1:0]   rd_data,
  output logic [NUM_EVT:0]   ovf,
  output logic               done,
  perf_event_monitor_if.master dump
);
  localparam int               NCNT     = NUM_EVT + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_EVT);
  localparam logic [1:0]       RUN      = 2'd0;
  localparam logic [1:0]       DUMP     = 2'd1;
  localparam logic [1:0]       DONE     = 2'd2;

  logic [1:0]                 state;
  logic [IDX_W-1:0]           dumpIdx;
  logic [NCNT-1:0][CNT_W-1:0] cnt;
  logic [NCNT-1:0]            inc;
  logic                       counting;

  // Slot 0 is the cycle counter; it ticks on every counting cycle.
  assign counting = (state == RUN) && en && !clr;
  assign inc      = counting ? {evt, 1'b1} : '0;

  for (genvar g = 0; g < NCNT; g++) begin : gCnt
    perfCounter #(.CNT_W(CNT_W)) uCnt (
      .clk (clk),
      .rst (rst),
      .clr (clr),
      .inc (inc[g]),
      .cnt (cnt[g]),
      .ovf (ovf[g])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RUN;
      dumpIdx <= '0;
    end else if (clr) begin
      state   <= RUN;
      dumpIdx <= '0;
    end else begin
      case (state)
        RUN: if (en && halt) begin
          state   <= DUMP;
          dumpIdx <= '0;
        end
        DUMP: if (dump.dump_ready) begin
          // Index parks on the last word once the stream completes.
          if (dumpIdx == LAST_IDX) state   <= DONE;
          else                     dumpIdx <= dumpIdx + IDX_W'(1);
        end
        DONE:    state <= DONE;
        default: state <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     rd_data <= '0;
    else if (rd_sel <= LAST_IDX) rd_data <= cnt[rd_sel];
    else                         rd_data <= '0;
  end

  assign dump.dump_valid = (state == DUMP);
  assign dump.dump_idx   = dumpIdx;
  assign dump.dump_data  = dump.dump_valid ? cnt[dumpIdx] : '0;
  assign dump.dump_last  = dump.dump_valid && (dumpIdx == LAST_IDX);
  assign done            = (state == DONE);
endmodule

// File: tb/tb_perf_event_monitor.sv
// Bench for perf_event_monitor: a 32-bit and a 4-bit instance share stimulus and
// are checked each cycle against unbounded true event counts.
module tb_perf_event_monitor;
  localparam int NE = 5;
  localparam int IW = $clog2(NE + 1);

  logic          clk = 1'b0, rst = 1'b1, en = 1'b0, halt = 1'b0, clr = 1'b0, ready = 1'b0;
  logic [NE-1:0] evt   = '0;
  logic [IW-1:0] rdSel = '0;
  logic [31:0]   rdA;
  logic [3:0]    rdB;
  logic [NE:0]   ovfA, ovfB;
  logic          doneA, doneB;
  int            checks = 0, errors = 0;

  perf_event_monitor_if #(.NUM_EVT(NE), .CNT_W(32)) ifA ();
  perf_event_monitor_if #(.NUM_EVT(NE), .CNT_W(4))  ifB ();
  assign ifA.dump_ready = ready;
  assign ifB.dump_ready = ready;

  perf_event_monitor #(.NUM_EVT(NE), .CNT_W(32)) dutA (
    .clk(clk), .rst(rst), .en(en), .evt(evt), .halt(halt), .clr(clr),
    .rd_sel(rdSel), .rd_data(rdA), .ovf(ovfA), .done(doneA), .dump(ifA)
  );
  perf_event_monitor #(.NUM_EVT(NE), .CNT_W(4)) dutB (
    .clk(clk), .rst(rst), .en(en), .evt(evt), .halt(halt), .clr(clr),
    .rd_sel(rdSel), .rd_data(rdB), .ovf(ovfB), .done(doneB), .dump(ifB)
  );

  always #5 clk = ~clk;

  // Reference: true (unbounded) counts plus run/dump/done phase.
  longint mCnt[NE+1];
  int     mState = 0;
  int     mIdx   = 0;

  function automatic longint view(longint c, int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
`ifdef PERF_WRAP_EN
    return c & mx;
`else
    return (c > mx) ? mx : c;
`endif
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  initial begin : model
    longint expRdA, expRdB;
    int     sel;
    foreach (mCnt[i]) mCnt[i] = 0;
    forever begin
      @(posedge clk);
      if (rst) begin
        foreach (mCnt[i]) mCnt[i] = 0;
        mState = 0; mIdx = 0; expRdA = 0; expRdB = 0;
      end else begin
        sel    = int'(rdSel);
        expRdA = (sel <= NE) ? view(mCnt[sel], 32) : 0;
        expRdB = (sel <= NE) ? view(mCnt[sel], 4)  : 0;
        if (clr) begin
          foreach (mCnt[i]) mCnt[i] = 0;
          mState = 0; mIdx = 0;
        end else if (mState == 0) begin
          if (en) begin
            mCnt[0]++;
            for (int i = 0; i < NE; i++) if (evt[i]) mCnt[i+1]++;
            if (halt) begin mState = 1; mIdx = 0; end
          end
        end else if (mState == 1 && ready) begin
          if (mIdx == NE) mState = 2;
          else            mIdx++;
        end
      end
      #1;
      chk("rdA", rdA, expRdA);
      chk("rdB", rdB, expRdB);
      for (int i = 0; i <= NE; i++) begin
        chk($sformatf("ovfA[%0d]", i), ovfA[i], mCnt[i] >= (longint'(1) << 32));
        chk($sformatf("ovfB[%0d]", i), ovfB[i], mCnt[i] >= 16);
      end
      chk("validA", ifA.dump_valid, mState == 1);
      chk("validB", ifB.dump_valid, mState == 1);
      chk("doneA", doneA, mState == 2);
      chk("doneB", doneB, mState == 2);
      if (mState == 1) begin
        chk("idxA", ifA.dump_idx, mIdx);
        chk("idxB", ifB.dump_idx, mIdx);
        chk("dataA", ifA.dump_data, view(mCnt[mIdx], 32));
        chk("dataB", ifB.dump_data, view(mCnt[mIdx], 4));
        chk("lastA", ifA.dump_last, mIdx == NE);
        chk("lastB", ifB.dump_last, mIdx == NE);
      end else if (mState == 0) begin
        chk("idxA run", ifA.dump_idx, 0);
        chk("idxB run", ifB.dump_idx, 0);
      end
    end
  end

  task automatic drive(logic e, logic [NE-1:0] ev, logic h, logic c, logic [IW-1:0] s, logic r);
    en = e; evt = ev; halt = h; clr = c; rdSel = s; ready = r;
    @(negedge clk);
  endtask

  initial begin : stim
    int sels[5] = '{0, 1, 3, 2, 7};
    int exps[5] = '{10, 10, 3, 0, 0};
    logic [NE-1:0] ev;

    repeat (2) @(negedge clk);
    chk("reset rd", rdA, 0);
    chk("reset valid", ifA.dump_valid, 0);
    chk("reset done", doneA, 0);
    chk("reset ovf", ovfB, 0);
    rst = 1'b0;

    // Basic count
    for (int c = 0; c < 10; c++) begin
      ev = 5'b00001;
      if (c <= 4 && c % 2 == 0) ev[2] = 1'b1;
      drive(1, ev, 0, 0, 0, 0);
    end
    for (int k = 0; k < 5; k++) begin
      drive(0, '0, 0, 0, IW'(sels[k]), 0);
      chk($sformatf("basic sel%0d", sels[k]), rdA, exps[k]);
    end

    // Halt and dump
    drive(0, '0, 0, 1, 0, 0);
    repeat (6) drive(1, '0, 0, 0, 0, 0);
    drive(1, '1, 1, 0, 0, 0);
    chk("dump valid", ifA.dump_valid, 1);
    repeat (3) begin
      drive(1, '1, 1, 0, 0, 0);
      chk("hold idx", ifA.dump_idx, 0);
      chk("hold data", ifA.dump_data, 7);
    end
    for (int k = 0; k <= NE; k++) begin
      ready = 1'b1;
      chk($sformatf("dump idx%0d", k), ifA.dump_idx, k);
      chk($sformatf("dump data%0d", k), ifA.dump_data, (k == 0) ? 7 : 1);
      chk($sformatf("dump last%0d", k), ifA.dump_last, k == NE);
      drive(1, '1, 1, 0, 0, 1);
    end
    chk("done set", doneA, 1);
    chk("valid drop", ifA.dump_valid, 0);
    repeat (3) drive(1, '1, 0, 0, 0, 0);
    drive(0, '0, 0, 0, 1, 0);
    chk("frozen ch0", rdA, 1);
    drive(0, '0, 0, 0, 0, 0);
    chk("frozen cyc", rdA, 7);

    // Saturation / wrap on the 4-bit instance
    drive(0, '0, 0, 1, 0, 0);
    repeat (18) drive(1, 5'b00001, 0, 0, 0, 0);
    drive(0, '0, 0, 0, 1, 0);
`ifdef PERF_WRAP_EN
    chk("wrap ch0", rdB, 2);
`else
    chk("sat ch0", rdB, 15);
`endif
    chk("wide ch0", rdA, 18);
    chk("ovf ch0", ovfB[1], 1);
    chk("ovf cyc", ovfB[0], 1);
    chk("ovf ch1 clear", ovfB[2], 0);

    // en gating and clr priority
    drive(0, '0, 0, 1, 0, 0);
    repeat (4) drive(0, '1, 1, 0, 0, 0);
    drive(0, '0, 0, 0, 0, 0);
    chk("gated cyc", rdA, 0);
    drive(1, 5'b00010, 0, 1, 2, 0);
    drive(0, '0, 0, 0, 2, 0);
    chk("clr wins", rdA, 0);
    chk("clr run", ifA.dump_valid, 0);

    // Abort mid-dump
    repeat (2) drive(1, '1, 0, 0, 0, 0);
    drive(1, '1, 1, 0, 0, 0);
    repeat (2) drive(0, '0, 0, 0, 0, 1);
    chk("abort idx", ifA.dump_idx, 2);
    chk("abort data", ifA.dump_data, 3);
    drive(0, '0, 0, 1, 0, 0);
    chk("abort valid", ifA.dump_valid, 0);
    chk("abort done", doneA, 0);
    repeat (2) drive(1, '0, 0, 0, 0, 0);
    drive(0, '0, 0, 0, 0, 0);
    chk("resume cyc", rdA, 2);

    // Async reset mid-dump
    drive(0, '0, 0, 1, 0, 0);
    repeat (20) drive(1, '1, 0, 0, 0, 0);
    drive(1, '1, 1, 0, 0, 0);
    drive(0, '0, 0, 0, 0, 1);
    chk("pre-rst valid", ifA.dump_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst valid", ifA.dump_valid, 0);
    chk("arst idx", ifA.dump_idx, 0);
    chk("arst data", ifA.dump_data, 0);
    chk("arst last", ifA.dump_last, 0);
    chk("arst rd", rdA, 0);
    chk("arst ovf", ovfB, 0);
    chk("arst done", doneA, 0);
    @(negedge clk);
    rst = 1'b0;
    drive(1, '1, 0, 0, 7, 0);
    chk("sel oob", rdA, 0);

    // Randomized traffic
    for (int c = 0; c < 2000; c++)
      drive($urandom_range(0, 3) != 0, NE'($urandom), $urandom_range(0, 15) == 0,
            $urandom_range(0, 39) == 0, IW'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/perf_event_monitor.md
Name: perf_event_monitor

Overview:
- Synthesizable performance-counter bank; generalised successor to the bench-side instruction and cache-hit/request tallies in the processor testbench.
- Sits beside the pipeline in proc_hier.
- Counts cycles plus NUM_EVT per-cycle event strobes (e.g. retire, I$ req/hit, D$ req/hit), with saturation and sticky overflow.
- Freezes on halt, then streams all counts out over a valid/ready port. A live 1-cycle-latency read port works in any state.

Parameters:
NUM_EVT, 5, number of event channels (>=1)
CNT_W, 32, width of every counter including cycle counter (>=4)
IDX_W, derived localparam = $clog2(NUM_EVT+1), index width covering cycle counter + events

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
en  in  1  counting enable (pipeline out of reset/stall-free window)
evt  in  NUM_EVT  event strobes, bit i = channel i, sampled on posedge clk
halt  in  1  processor halt observed this cycle
clr  in  1  synchronous clear / restart
rd_sel  in  IDX_W  live read select: 0 = cycle counter, i+1 = evt channel i
rd_data  out  CNT_W  registered value of selected counter
ovf  out  NUM_EVT+1  sticky overflow, bit 0 cycle, bit i+1 channel i
dump_valid  out  1  dump word valid
dump_ready  in  1  consumer accepts dump word
dump_idx  out  IDX_W  index of current dump word
dump_data  out  CNT_W  value of current dump word
dump_last  out  1  current dump word is index NUM_EVT
done  out  1  dump complete, held until clr/rst

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-high. Port names are clk and rst.
- Reset values: all counters 0, ovf 0, rd_data 0, dump_valid 0, dump_idx 0, dump_data 0, dump_last 0, done 0, state RUN.
- States: RUN, DUMP, DONE.
- RUN, en=1: cycle counter +1; each counter i with evt[i]=1 +1; all in the same cycle.
- RUN, en=0: nothing counts; evt and halt are ignored.
- RUN, en=1 and halt=1: that cycle's events and cycle are counted. Next state is DUMP with dump_idx=0.
- DUMP:
  - Counters frozen; evt, en and halt ignored.
  - dump_valid=1; dump_data = counter[dump_idx] (combinational from frozen counters); dump_last = (dump_idx==NUM_EVT).
  - Word transfers when dump_valid & dump_ready; then dump_idx +1.
  - Transfer with dump_last=1 → DONE; dump_valid drops next cycle.
  - dump_ready low holds the word stable indefinitely.
- DONE: done=1, dump_valid=0, counters frozen; stays here until clr or rst.
- clr (any state, priority over everything except rst):
  - Next cycle: counters 0, ovf 0, dump_idx 0, done 0, state RUN.
  - Events and halt in the clr cycle are discarded.
  - clr mid-dump aborts the stream; dump_valid drops next cycle.
- Arithmetic: counters are unsigned CNT_W.
  - Increment while at 2^CNT_W-1 leaves the value at max and sets the corresponding ovf bit.
  - ovf is sticky until clr/rst.
- Live read: rd_data <= counter[rd_sel] every cycle (1-cycle latency), any state. The value is pre-increment of that edge.
  - rd_sel > NUM_EVT returns 0.
- rst asserted mid-operation (including mid-dump): immediate return to reset values.

Optional Feature:
- Macro PERF_WRAP_EN.
- Defined: counters wrap modulo 2^CNT_W (max+1 → 0). The ovf bit is still set on the wrapping increment.
- Undefined: saturating behaviour as above.
- All other behaviour is identical.

Test Plan:
- Basic count, NUM_EVT=5, CNT_W=32: rst, en=1, 10 cycles with evt=5'b00001 on cycles 0-9 and evt[2] on cycles 0,2,4 → rd_sel=0 reads 10, rd_sel=1 reads 10, rd_sel=3 reads 3, rd_sel=2 reads 0. All reads have 1-cycle latency.
- Halt and dump: 7 enabled cycles, halt on the 7th with evt=5'b11111 → dump words idx0=7, idx1..5=1. With dump_ready low 3 cycles, the word is held stable. dump_last is set only on idx5; done=1 after the last transfer; later evt pulses leave counts unchanged.
- Saturation, CNT_W=4: 18 cycles evt[0]=1 → counter 1 reads 15, ovf[1]=1, ovf[0]=1. With PERF_WRAP_EN, counter 1 reads 2 and ovf[1]=1.
- en gating and simultaneous clr: 4 cycles en=0 with evt high → all 0. Then en=1 with evt[1]=1 and clr=1 in the same cycle → next cycle counter 2 = 0, state RUN.
- Abort: clr while dump_idx=2 in DUMP → next cycle dump_valid=0, counters 0, ovf 0, done 0, counting resumes.
- Async reset mid-dump: assert rst between clock edges → outputs go to reset values before the next posedge. rd_sel=7 with NUM_EVT=5 returns 0.
